fetch_datapath: RTL and testbench

FETCH_DATAPATH -- requirements
Module: fetch_datapath

---
 rtl/fetch_datapath.sv | 147 ++++++++++++++
 tb/tb_fetch_datapath.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_datapath.sv
// Multi-cycle fetch datapath: PC, instruction register, operand-select ALU and
// a small FSM sequencing instruction fetches and data stores over one memory port.
module fetch_datapath #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     PC_RESET = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCwrite,
  input  logic             AluSrcA,
  input  logic [1:0]       AluSrcB,
  input  logic [2:0]       ALUFct,
  input  logic             Wr,
  input  logic [WIDTH-1:0] A_reg,
  input  logic [WIDTH-1:0] B_reg,
  input  logic [WIDTH-1:0] Imm,
  output logic             MemReq,
  output logic             MemWe,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  input  logic [31:0]      MemRData,
  input  logic             MemReady,
  output logic [WIDTH-1:0] PC,
  output logic [31:0]      Instr,
  output logic             InstrValid,
  output logic [WIDTH-1:0] AluResult,
  output logic             Zero,
  output logic             Stall
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StStore} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] st_addr_q, st_addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]      instr_q, instr_d;
  logic             ivalid_q, ivalid_d;
  logic             pend_q, pend_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             slt;

  always_comb begin
    alu_a = AluSrcA ? A_reg : pc_q;
    unique case (AluSrcB)
      2'b00:   alu_b = B_reg;
      2'b01:   alu_b = WIDTH'(4);
      2'b10:   alu_b = Imm;
      default: alu_b = Imm << 2;
    endcase
    slt = $signed(alu_a) < $signed(alu_b);
    unique case (ALUFct)
      3'b000:  alu_y = alu_a & alu_b;
      3'b001:  alu_y = alu_a + alu_b;
      3'b010:  alu_y = alu_a - alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = alu_a ^ alu_b;
      3'b101:  alu_y = {{(WIDTH-1){1'b0}}, slt};
      3'b110:  alu_y = alu_a << alu_b[4:0];
      default: alu_y = alu_b;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    st_addr_d = st_addr_q;
    wdata_d   = wdata_q;
    instr_d   = instr_q;
    ivalid_d  = ivalid_q;
    pend_d    = pend_q;
    armed_d   = 1'b1;
    unique case (state_q)
      // One full idle cycle after reset release before the first fetch.
      StIdle: if (armed_q) state_d = StFetch;
      StFetch: begin
        if (MemReady) begin
          instr_d  = MemRData;
          ivalid_d = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (Wr) begin
          st_addr_d = alu_y;
          wdata_d   = B_reg;
          state_d   = StStore;
          if (PCwrite) begin
            pc_d   = alu_y;
            pend_d = 1'b1;
          end
        end else if (PCwrite) begin
          pc_d     = alu_y;
          ivalid_d = 1'b0;
          state_d  = StFetch;
        end
      end
      default: begin
        if (MemReady) begin
          if (pend_q) begin
            pend_d   = 1'b0;
            ivalid_d = 1'b0;
            state_d  = StFetch;
          end else begin
            state_d  = StHold;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      pc_q      <= PC_RESET;
      st_addr_q <= '0;
      wdata_q   <= '0;
      instr_q   <= '0;
      ivalid_q  <= 1'b0;
      pend_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      st_addr_q <= st_addr_d;
      wdata_q   <= wdata_d;
      instr_q   <= instr_d;
      ivalid_q  <= ivalid_d;
      pend_q    <= pend_d;
      armed_q   <= armed_d;
    end
  end

  // Request outputs decode straight from registered state so reset drops them at once.
  assign MemReq     = (state_q == StFetch) || (state_q == StStore);
  assign MemWe      = (state_q == StStore);
  assign MemAddr    = (state_q == StStore) ? st_addr_q : pc_q;
  assign MemWData   = wdata_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = ivalid_q;
  assign AluResult  = alu_y;
  assign Zero       = (alu_y == '0);
  assign Stall      = (state_q != StHold);

endmodule

// File: tb/tb_fetch_datapath.sv
// Self-checking bench for fetch_datapath: ALU vector table plus fetch/store sequences.
module tb_fetch_datapath;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          PCwrite, AluSrcA, Wr, MemReady;
  logic [1:0]    AluSrcB;
  logic [2:0]    ALUFct;
  logic [W-1:0]  A_reg, B_reg, Imm;
  logic [31:0]   MemRData;
  logic          MemReq, MemWe, InstrValid, Zero, Stall;
  logic [W-1:0]  MemAddr, MemWData, PC, AluResult;
  logic [31:0]   Instr;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] sb_q[$];

  fetch_datapath #(.WIDTH(W), .PC_RESET(32'h0)) dut (
    .Clk(Clk), .Reset(Reset), .PCwrite(PCwrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .ALUFct(ALUFct), .Wr(Wr), .A_reg(A_reg), .B_reg(B_reg), .Imm(Imm),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady), .PC(PC), .Instr(Instr),
    .InstrValid(InstrValid), .AluResult(AluResult), .Zero(Zero), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         srca;
    logic [1:0]   srcb;
    logic [2:0]   fct;
    logic [31:0]  a, b, imm;
    logic [31:0]  exp_y;
    logic         exp_z;
  } alu_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Fetch scoreboard: expected word queued when the memory response is driven.
  task automatic fetch_respond(input logic [31:0] word);
    MemRData = word;
    MemReady = 1'b1;
    sb_q.push_back(word);
    tick();
    MemReady = 1'b0;
    if (sb_q.size() == 0) check("fetch_sb_empty", 1, 0);
    else check("instr_captured", Instr, sb_q.pop_front());
    check("instr_valid", InstrValid, 1);
    check("hold_stall", Stall, 0);
  endtask

  alu_vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b1, 2'b00, 3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 32'h00F0_000F, 1'b0};
    vecs[1]  = '{1'b1, 2'b01, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0003, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 3'b010, 32'h5, 32'h5, 32'h0, 32'h0, 1'b1};
    vecs[3]  = '{1'b1, 2'b00, 3'b010, 32'h3, 32'h5, 32'h0, 32'hFFFF_FFFE, 1'b0};
    vecs[4]  = '{1'b1, 2'b10, 3'b011, 32'h1200, 32'h0, 32'h34, 32'h1234, 1'b0};
    vecs[5]  = '{1'b1, 2'b11, 3'b100, 32'hFFFF_0000, 32'h0, 32'h4000_0001, 32'hFFFF_0004, 1'b0};
    vecs[6]  = '{1'b1, 2'b00, 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 3'b101, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 2'b00, 3'b110, 32'h1, 32'h25, 32'h0, 32'h20, 1'b0};
    vecs[9]  = '{1'b1, 2'b11, 3'b111, 32'h7, 32'h0, 32'h10, 32'h40, 1'b0};
    vecs[10] = '{1'b0, 2'b01, 3'b001, 32'h0, 32'h0, 32'h0, 32'h4, 1'b0};

    Reset = 1'b0; PCwrite = 0; Wr = 0; AluSrcA = 0; AluSrcB = 2'b00; ALUFct = 3'b000;
    A_reg = '0; B_reg = '0; Imm = '0; MemRData = '0; MemReady = 1'b0;
    #23;
    check("rst_memreq", MemReq, 0);
    check("rst_memwe", MemWe, 0);
    check("rst_stall", Stall, 1);
    check("rst_pc", PC, 0);
    check("rst_instr", Instr, 0);
    check("rst_ivalid", InstrValid, 0);
    check("rst_wdata", MemWData, 0);

    tick();
    Reset = 1'b1;
    MemReady = 1'b1;
    MemRData = 32'h00A0_0093;
    tick();
    check("idle_memreq", MemReq, 0);
    check("idle_stall", Stall, 1);
    tick();
    check("fetch0_req", MemReq, 1);
    check("fetch0_we", MemWe, 0);
    check("fetch0_addr", MemAddr, 0);
    MemReady = 1'b0;
    fetch_respond(32'h00A0_0093);
    check("hold_memreq", MemReq, 0);

    // ALU table, applied in HOLD with no control requests.
    for (int i = 0; i < 11; i++) begin
      AluSrcA = vecs[i].srca; AluSrcB = vecs[i].srcb; ALUFct = vecs[i].fct;
      A_reg = vecs[i].a; B_reg = vecs[i].b; Imm = vecs[i].imm;
      sb_q.push_back(vecs[i].exp_y);
      sb_q.push_back({31'b0, vecs[i].exp_z});
      #1;
      check($sformatf("alu_y[%0d]", i), AluResult, sb_q.pop_front());
      check($sformatf("alu_z[%0d]", i), Zero, sb_q.pop_front());
    end
    tick();
    check("hold_stays", Stall, 0);

    // PC+4 jump
    AluSrcA = 0; AluSrcB = 2'b01; ALUFct = 3'b001; PCwrite = 1;
    tick();
    check("jmp_pc", PC, 4);
    check("jmp_ivalid", InstrValid, 0);
    check("jmp_req", MemReq, 1);
    check("jmp_addr", MemAddr, 4);

    // Stalled fetch with PCwrite held high
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("wait_stall[%0d]", i), Stall, 1);
      check($sformatf("wait_pc[%0d]", i), PC, 4);
      check($sformatf("wait_addr[%0d]", i), MemAddr, 4);
      check($sformatf("wait_req[%0d]", i), MemReq, 1);
    end
    PCwrite = 0;
    fetch_respond(32'h1234_5678);
    check("wait_pc_after", PC, 4);

    // Store from HOLD
    A_reg = 100; Imm = 8; B_reg = 32'hDEAD; AluSrcA = 1; AluSrcB = 2'b10; ALUFct = 3'b001;
    Wr = 1;
    tick();
    Wr = 0; A_reg = 0; B_reg = 0;
    check("st_req", MemReq, 1);
    check("st_we", MemWe, 1);
    check("st_addr", MemAddr, 108);
    check("st_wdata", MemWData, 32'hDEAD);
    check("st_stall", Stall, 1);
    tick();
    check("st_addr_stable", MemAddr, 108);
    check("st_wdata_stable", MemWData, 32'hDEAD);
    MemReady = 1;
    tick();
    MemReady = 0;
    check("st_back_hold", Stall, 0);
    check("st_back_req", MemReq, 0);
    check("st_pc", PC, 4);
    check("st_ivalid", InstrValid, 1);

    // Simultaneous jump and store
    A_reg = 16; AluSrcB = 2'b01; B_reg = 32'h55; PCwrite = 1; Wr = 1;
    tick();
    PCwrite = 0; Wr = 0;
    check("js_addr", MemAddr, 20);
    check("js_we", MemWe, 1);
    check("js_pc", PC, 20);
    check("js_wdata", MemWData, 32'h55);
    MemReady = 1;
    tick();
    MemReady = 0;
    check("js_fetch_req", MemReq, 1);
    check("js_fetch_we", MemWe, 0);
    check("js_fetch_addr", MemAddr, 20);
    check("js_ivalid", InstrValid, 0);
    fetch_respond(32'hCAFE_F00D);

    // Reset asserted mid-store
    A_reg = 200; AluSrcB = 2'b10; Imm = 8; Wr = 1;
    tick();
    Wr = 0;
    check("rs_in_store", MemWe, 1);
    #1 Reset = 1'b0;
    #1;
    check("rs_memreq_async", MemReq, 0);
    check("rs_pc", PC, 0);
    check("rs_wdata", MemWData, 0);
    check("rs_stall", Stall, 1);
    tick();
    Reset = 1'b1;
    tick();
    check("rs_idle", MemReq, 0);
    tick();
    check("rs_fetch", MemReq, 1);
    check("rs_fetch_addr", MemAddr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
